// File: rtl/sc_config_master.sv
// Configuration-bus master: queues host register commands in a small FIFO and
// replays them one at a time as Avalon-MM transfers, returning read responses.
module sc_config_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic [3:0]  cmd_addr_i,
    input  logic [31:0] cmd_data_i,
    input  logic [3:0]  cmd_be_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic        err_sticky_o,
    output logic        busy_o,
    output logic [3:0]  avm_address_o,
    output logic [31:0] avm_writedata_o,
    output logic [3:0]  avm_byteenable_o,
    output logic        avm_write_o,
    output logic        avm_read_o,
    output logic        avm_chipselect_o,
    input  logic [31:0] avm_readdata_i,
    input  logic        avm_waitrequest_n_i
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [7:0]  TMO_C   = 8'(TIMEOUT);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    // FIFO entry layout: {write, addr[3:0], data[31:0], be[3:0]}
    logic [40:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [1:0]    r_state;
    logic [7:0]    r_tmo;

    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic [40:0]   w_head;

    assign w_full      = (r_count == DEPTH_C);
    assign cmd_ready_o = !w_full;
    assign w_push      = cmd_valid_i && !w_full;
    assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
    assign w_head      = r_mem[r_rptr];
    assign busy_o      = (r_count != '0) || (r_state != S_IDLE);

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= {cmd_write_i, cmd_addr_i, cmd_data_i, cmd_be_i};
        end
    end

    // Depth is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state          <= S_IDLE;
            r_tmo            <= '0;
            avm_address_o    <= '0;
            avm_writedata_o  <= '0;
            avm_byteenable_o <= '0;
            avm_write_o      <= 1'b0;
            avm_read_o       <= 1'b0;
            avm_chipselect_o <= 1'b0;
            rsp_valid_o      <= 1'b0;
            rsp_data_o       <= '0;
            rsp_err_o        <= 1'b0;
            err_sticky_o     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        avm_chipselect_o <= 1'b1;
                        avm_write_o      <= w_head[40];
                        avm_read_o       <= !w_head[40];
                        avm_address_o    <= w_head[39:36];
                        avm_writedata_o  <= w_head[35:4];
                        avm_byteenable_o <= w_head[40] ? w_head[3:0] : 4'hF;
                        r_tmo            <= '0;
                        r_state          <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // A completing slave wins over a timeout landing in the same cycle.
                    if (avm_waitrequest_n_i) begin
                        avm_chipselect_o <= 1'b0;
                        avm_write_o      <= 1'b0;
                        avm_read_o       <= 1'b0;
                        if (avm_read_o) begin
                            rsp_data_o  <= avm_readdata_i;
                            rsp_err_o   <= 1'b0;
                            rsp_valid_o <= 1'b1;
                            r_state     <= S_RESP;
                        end else begin
                            r_state     <= S_IDLE;
                        end
                    end else if (r_tmo == TMO_C) begin
                        avm_chipselect_o <= 1'b0;
                        avm_write_o      <= 1'b0;
                        avm_read_o       <= 1'b0;
                        err_sticky_o     <= 1'b1;
                        if (avm_read_o) begin
                            rsp_data_o  <= '0;
                            rsp_err_o   <= 1'b1;
                            rsp_valid_o <= 1'b1;
                            r_state     <= S_RESP;
                        end else begin
                            r_state     <= S_IDLE;
                        end
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_config_master.sv
// Bench for sc_config_master: directed scenarios plus a randomized command
// stream checked against a queue-based transaction model.
module tb_sc_config_master;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_write_i = 1'b0;
    logic [3:0]  cmd_addr_i = '0;
    logic [31:0] cmd_data_i = '0;
    logic [3:0]  cmd_be_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic        err_sticky_o;
    logic        busy_o;
    logic [3:0]  avm_address_o;
    logic [31:0] avm_writedata_o;
    logic [3:0]  avm_byteenable_o;
    logic        avm_write_o;
    logic        avm_read_o;
    logic        avm_chipselect_o;
    logic [31:0] avm_readdata_i;
    logic        avm_waitrequest_n_i = 1'b0;

    sc_config_master #(.FIFO_DEPTH(4), .TIMEOUT(255)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .cmd_valid_i         (cmd_valid_i),
        .cmd_ready_o         (cmd_ready_o),
        .cmd_write_i         (cmd_write_i),
        .cmd_addr_i          (cmd_addr_i),
        .cmd_data_i          (cmd_data_i),
        .cmd_be_i            (cmd_be_i),
        .rsp_valid_o         (rsp_valid_o),
        .rsp_ready_i         (rsp_ready_i),
        .rsp_data_o          (rsp_data_o),
        .rsp_err_o           (rsp_err_o),
        .err_sticky_o        (err_sticky_o),
        .busy_o              (busy_o),
        .avm_address_o       (avm_address_o),
        .avm_writedata_o     (avm_writedata_o),
        .avm_byteenable_o    (avm_byteenable_o),
        .avm_write_o         (avm_write_o),
        .avm_read_o          (avm_read_o),
        .avm_chipselect_o    (avm_chipselect_o),
        .avm_readdata_i      (avm_readdata_i),
        .avm_waitrequest_n_i (avm_waitrequest_n_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        w;
        logic [3:0]  a;
        logic [31:0] d;
        logic [3:0]  b;
    } xfer_t;

    // Slave model: read data is a fixed pattern keyed by address.
    logic [31:0] rd_base = 32'hCAFEF00D;
    assign avm_readdata_i = rd_base ^ {28'h0, avm_address_o};

    xfer_t       mon_q[$];
    logic [32:0] rsp_q[$];
    int          anom = 0;

    always @(posedge clk_i) begin
        if (avm_chipselect_o && avm_waitrequest_n_i)
            mon_q.push_back({avm_write_o, avm_address_o, avm_writedata_o, avm_byteenable_o});
        if (rsp_valid_o && rsp_ready_i)
            rsp_q.push_back({rsp_err_o, rsp_data_o});
        if (avm_chipselect_o ? (avm_read_o == avm_write_o) : (avm_read_o || avm_write_o))
            anom <= anom + 1;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic w, input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
        cmd_valid_i = 1'b1;
        cmd_write_i = w;
        cmd_addr_i  = a;
        cmd_data_i  = d;
        cmd_be_i    = b;
        for (int k = 0; k < 50 && !cmd_ready_o; k++) step();
        chk("push_ready", cmd_ready_o, 1);
        step();
        cmd_valid_i = 1'b0;
    endtask

    int    base_m;
    int    base_r;
    int    held;
    int    cs_cnt;
    int    remaining;
    int    ri;
    logic  acc;
    xfer_t exp_q[$];
    xfer_t e;

    initial begin
        // Reset state
        step();
        step();
        chk("rst_ready", cmd_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_cs", avm_chipselect_o, 0);
        chk("rst_rd", avm_read_o, 0);
        chk("rst_wr", avm_write_o, 0);
        chk("rst_rspv", rsp_valid_o, 0);
        chk("rst_rspd", rsp_data_o, 0);
        chk("rst_err", rsp_err_o, 0);
        chk("rst_sticky", err_sticky_o, 0);
        rst_i = 1'b0;
        step();

        // Single write, slave ready immediately
        avm_waitrequest_n_i = 1'b1;
        base_m = mon_q.size();
        push(1'b1, 4'h3, 32'h12345678, 4'hF);
        chk("w_cs_n1", avm_chipselect_o, 0);
        step();
        chk("w_cs_n2", avm_chipselect_o, 1);
        chk("w_wr_n2", avm_write_o, 1);
        chk("w_rd_n2", avm_read_o, 0);
        chk("w_addr", avm_address_o, 4'h3);
        chk("w_data", avm_writedata_o, 32'h12345678);
        chk("w_be", avm_byteenable_o, 4'hF);
        step();
        chk("w_cs_n3", avm_chipselect_o, 0);
        chk("w_rspv", rsp_valid_o, 0);
        step();
        chk("w_busy_n4", busy_o, 0);
        chk("w_count", mon_q.size() - base_m, 1);

        // Read with three wait cycles
        avm_waitrequest_n_i = 1'b0;
        rd_base = 32'hCAFEF00D;
        push(1'b0, 4'h0, 32'h0, 4'h0);
        step();
        chk("r_rd_first", avm_read_o, 1);
        chk("r_be", avm_byteenable_o, 4'hF);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("r_rd_held", avm_read_o, 1);
        end
        avm_waitrequest_n_i = 1'b1;
        step();
        avm_waitrequest_n_i = 1'b0;
        chk("r_rd_done", avm_read_o, 0);
        chk("r_rspv", rsp_valid_o, 1);
        chk("r_rspd", rsp_data_o, 32'hCAFEF00D);
        chk("r_err", rsp_err_o, 0);
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        chk("r_rspv_clr", rsp_valid_o, 0);

        // Five writes against a stalled slave fill the FIFO
        base_m = mon_q.size();
        for (int i = 0; i < 5; i++) begin
            chk("f_ready_pre", cmd_ready_o, 1);
            push(1'b1, 4'(i + 8), 32'hA000_0000 + 32'(i), 4'(i + 1));
        end
        chk("f_ready_full", cmd_ready_o, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("f_ready_hold", cmd_ready_o, 0);
        end
        avm_waitrequest_n_i = 1'b1;
        step();
        step();
        chk("f_ready_resume", cmd_ready_o, 1);
        for (int k = 0; k < 50 && busy_o; k++) step();
        chk("f_drained", busy_o, 0);
        chk("f_count", mon_q.size() - base_m, 5);
        for (int i = 0; i < 5; i++) begin
            e = {1'b1, 4'(i + 8), 32'hA000_0000 + 32'(i), 4'(i + 1)};
            chk("f_order", mon_q[base_m + i], e);
        end

        // Read with waitrequest stuck low times out
        avm_waitrequest_n_i = 1'b0;
        base_m = mon_q.size();
        push(1'b0, 4'h5, 32'h0, 4'h0);
        held = 0;
        for (int k = 0; k < 400; k++) begin
            step();
            if (avm_read_o) held++;
            else break;
        end
        chk("t_held", held, 256);
        chk("t_rspv", rsp_valid_o, 1);
        chk("t_rspd", rsp_data_o, 0);
        chk("t_err", rsp_err_o, 1);
        chk("t_sticky", err_sticky_o, 1);
        chk("t_noxfer", mon_q.size() - base_m, 0);
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        step();
        chk("t_sticky_keep", err_sticky_o, 1);

        // Held-off read response blocks queued writes
        avm_waitrequest_n_i = 1'b1;
        rd_base = 32'h1357_9BDF;
        push(1'b0, 4'h7, 32'h0, 4'h0);
        push(1'b1, 4'h1, 32'h1111_1111, 4'h3);
        push(1'b1, 4'h2, 32'h2222_2222, 4'hC);
        for (int k = 0; k < 20 && !rsp_valid_o; k++) step();
        base_m = mon_q.size();
        cs_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (avm_chipselect_o) cs_cnt++;
        end
        chk("h_nostrobe", cs_cnt, 0);
        chk("h_rspv", rsp_valid_o, 1);
        chk("h_rspd", rsp_data_o, 32'h1357_9BDF ^ 32'h7);
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        for (int k = 0; k < 50 && busy_o; k++) step();
        chk("h_count", mon_q.size() - base_m, 2);
        chk("h_first", mon_q[base_m], {1'b1, 4'h1, 32'h1111_1111, 4'h3});
        chk("h_second", mon_q[base_m + 1], {1'b1, 4'h2, 32'h2222_2222, 4'hC});
        chk("h_sticky", err_sticky_o, 1);

        // Reset while an access is in flight with three commands queued
        avm_waitrequest_n_i = 1'b0;
        for (int i = 0; i < 4; i++) push(1'b1, 4'(i), 32'(i), 4'hF);
        step();
        chk("x_cs_before", avm_chipselect_o, 1);
        rst_i = 1'b1;
        #1;
        chk("x_cs_async", avm_chipselect_o, 0);
        chk("x_busy_async", busy_o, 0);
        chk("x_ready_async", cmd_ready_o, 1);
        chk("x_sticky_clr", err_sticky_o, 0);
        step();
        rst_i = 1'b0;
        avm_waitrequest_n_i = 1'b1;
        base_m = mon_q.size();
        for (int k = 0; k < 5; k++) step();
        chk("x_busy_after", busy_o, 0);
        chk("x_noxfer", mon_q.size() - base_m, 0);

        // Randomized command stream against the transaction model
        rd_base   = $urandom;
        base_m    = mon_q.size();
        base_r    = rsp_q.size();
        remaining = 24;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (remaining > 0 && $urandom_range(0, 2) != 0) begin
                cmd_valid_i = 1'b1;
                cmd_write_i = 1'($urandom);
                cmd_addr_i  = 4'($urandom);
                cmd_data_i  = $urandom;
                cmd_be_i    = 4'($urandom);
            end else begin
                cmd_valid_i = 1'b0;
            end
            acc = cmd_valid_i && cmd_ready_o;
            avm_waitrequest_n_i = ($urandom_range(0, 3) != 0);
            rsp_ready_i = 1'($urandom);
            if (acc) exp_q.push_back({cmd_write_i, cmd_addr_i, cmd_data_i, cmd_be_i});
            step();
            if (acc) remaining--;
            if (remaining == 0 && !busy_o && !rsp_valid_o) break;
        end
        cmd_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
        chk("rnd_done", (remaining == 0) && !busy_o, 1);
        chk("rnd_xfers", mon_q.size() - base_m, exp_q.size());
        ri = 0;
        foreach (exp_q[i]) begin
            e = exp_q[i];
            if (!e.w) e.b = 4'hF;
            chk("rnd_xfer", mon_q[base_m + i], e);
            if (!e.w) begin
                chk("rnd_rsp", rsp_q[base_r + ri], {1'b0, rd_base ^ {28'h0, e.a}});
                ri++;
            end
        end
        chk("rnd_rsps", rsp_q.size() - base_r, ri);
        chk("strobe_shape", anom, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
